ll_comp_unit_core: RTL and testbench

LL_COMP_UNIT_CORE -- requirements
Module: ll_comp_unit

---
 rtl/ll_comp_unit_core.sv | 76 +++++++
 tb/tb_ll_comp_unit_core.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ll_comp_unit_core.sv
// Line-length feature extractor: running sum of |x[n]-x[n-1]| over the last
// 2^window_log2 differences of enabled samples, saturated on the output.
module ll_comp_unit_core #(
  parameter int input_width = 31,
  parameter int window_log2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [input_width:0] din,
  input  logic                 en,
  output logic [input_width:0] dout
);

  localparam int DW     = input_width + 1;
  localparam int AW     = DW + window_log2;
  localparam int WINDOW = 1 << window_log2;

  localparam logic [AW-1:0] SAT_LIMIT =
    {{(AW - input_width){1'b0}}, {input_width{1'b1}}};
  localparam logic [window_log2-1:0] PTR_ONE = 1;

  logic [DW-1:0]          r_prev;
  logic                   r_primed;
  logic [DW-1:0]          r_buf [WINDOW];
  logic [window_log2-1:0] r_ptr;
  logic [AW-1:0]          r_acc;

  logic signed [DW:0]     w_diff;
  logic [DW-1:0]          w_abs;
  logic [DW-1:0]          w_old;
  logic [AW-1:0]          w_acc_next;
  logic [DW-1:0]          w_dout_next;

  // One extra bit keeps the difference of two full-range samples exact.
  assign w_diff = $signed({din[input_width], din})
                - $signed({r_prev[input_width], r_prev});

  // The magnitude is at most 2^DW-1, so dropping the sign bit loses nothing.
  assign w_abs = w_diff[DW] ? DW'(-w_diff) : DW'(w_diff);

  assign w_old = r_buf[r_ptr];

  // The overwritten entry is already part of r_acc, so this never underflows.
  assign w_acc_next = r_acc + AW'(w_abs) - AW'(w_old);

  assign w_dout_next = (w_acc_next > SAT_LIMIT) ? SAT_LIMIT[DW-1:0]
                                                : w_acc_next[DW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_ptr    <= '0;
      r_acc    <= '0;
      dout     <= '0;
      // NOTE: the window must read as all zeros after reset so that the
      // partial-window sum and the subtract-oldest update stay correct;
      // this is why the buffer sits in flops with a reset, not in a RAM.
      for (int i = 0; i < WINDOW; i++) begin
        r_buf[i] <= '0;
      end
    end else if (en) begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so r_prev/r_acc read here are the old ones.
      r_prev   <= din;
      r_primed <= 1'b1;
      if (r_primed) begin
        r_buf[r_ptr] <= w_abs;
        r_ptr        <= r_ptr + PTR_ONE;
        r_acc        <= w_acc_next;
        dout         <= w_dout_next;
      end
    end
  end

endmodule

// File: tb/tb_ll_comp_unit_core.sv
// Directed bench for ll_comp_unit_core: a window-sum model fills a scoreboard
// queue at drive time; each output sample pops and compares one entry.
module tb_ll_comp_unit_core;

  localparam int     WIN = 16;
  localparam longint SAT = 64'h0000_0000_7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        en;
  logic [31:0] dout;

  longint hist[$];
  longint exp_q[$];
  int     pass_cnt  = 0;
  int     total_cnt = 0;
  logic [31:0] rv;

  ll_comp_unit_core #(.input_width(31), .window_log2(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .en   (en),
    .dout (dout)
  );

  always #5 clk = ~clk;

  // Reference: recompute the whole window from the captured-sample history.
  function automatic longint model_out();
    longint s = 0;
    longint d;
    for (int i = 1; i < hist.size(); i++) begin
      d = hist[i] - hist[i-1];
      s += (d < 0) ? -d : d;
    end
    return (s > SAT) ? SAT : s;
  endfunction

  task automatic check_out(input string tag);
    longint      e;
    logic [31:0] e32;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, dout=%0d", tag, dout);
      return;
    end
    e   = exp_q.pop_front();
    e32 = e[31:0];
    assert (dout === e32) pass_cnt++;
    else $error("FAIL %s: dout=%0d expected=%0d", tag, dout, e32);
  endtask

  task automatic cap(input logic [31:0] v, input string tag);
    din = v;
    en  = 1'b1;
    hist.push_back(longint'($signed(v)));
    if (hist.size() > WIN + 1) void'(hist.pop_front());
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    check_out(tag);
  endtask

  task automatic idle(input int n, input string tag);
    en = 1'b0;
    repeat (n) begin
      din = $urandom;
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(model_out());
      check_out(tag);
    end
  endtask

  // Called just after a falling edge: reset lands between clock edges.
  task automatic reset_async(input string tag);
    #2 rst = 1'b0;
    hist.delete();
    exp_q.push_back(0);
    #1 check_out(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    exp_q.push_back(0);
    #1 check_out("reset_state");
    @(negedge clk);
    rst = 1'b1;

    // First capture only primes.
    cap(32'd1, "prime_only");

    // Unit ramp: partial window climbs to 15, then full window holds at 16.
    reset_async("rst_clear_a");
    for (int i = 0; i < 20; i++) cap(32'(i), "ramp");

    // +5/-5 alternation: 10 per difference, capped by the window at 160.
    reset_async("rst_clear_b");
    for (int i = 0; i < 20; i++) cap((i % 2) ? -32'sd5 : 32'sd5, "alt5");

    // en=0 gap is transparent.
    reset_async("rst_clear_c");
    for (int i = 0; i < 5; i++) cap(32'(i), "gap_ramp");
    idle(3, "gap_hold");
    cap(32'd6, "gap_resume");

    // Full-scale swing saturates dout; a flat run drains the window to 0.
    reset_async("rst_clear_d");
    cap(32'h8000_0000, "sat_prime");
    cap(32'h7FFF_FFFF, "sat_peak");
    for (int i = 0; i < 16; i++) cap(32'h7FFF_FFFF, "sat_drain");

    // Mixed small and full-range samples with occasional gaps.
    reset_async("rst_clear_e");
    for (int i = 0; i < 40; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      cap(rv, "random");
      if ($urandom_range(0, 7) == 0) idle(1, "random_gap");
    end

    // Mid-window reset discards history; the next capture primes again.
    cap(32'd0,   "mid_a");
    cap(32'd100, "mid_b");
    cap(32'd50,  "mid_c");
    reset_async("mid_window_rst");
    cap(32'd7, "post_rst_prime");
    cap(32'd9, "post_rst_diff");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
